// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM stage.
// Access-size codes, FSM state codes, lane/alignment helpers.
package mem_access_pkg;

   localparam logic [1:0] LS_B = 2'b00;
   localparam logic [1:0] LS_H = 2'b01;
   localparam logic [1:0] LS_W = 2'b10;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'b00,
      MEM_REQ  = 2'b01,
      MEM_RESP = 2'b10,
      MEM_DONE = 2'b11
   } mem_state_e;

   // Halfwords need an even address; words (and any other size) need
   // a word-aligned address.
   function automatic logic misaligned(input logic [1:0] typ,
                                       input logic [1:0] off);
      logic r;
      r = 1'b0;
      if (typ == LS_H)
         r = off[0];
      else if (typ != LS_B)
         r = (off != 2'b00);
      return r;
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] typ,
                                           input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      if (typ == LS_B)
         be = 4'b0001 << off;
      else if (typ == LS_H)
         be = 4'b0011 << off;
      return be;
   endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load data formatter: lane-shifts bus read data and sign/zero extends.
// Ports: rdata_i, off_i (addr[1:0]), type_i, sign_i -> data_o.
module mem_load_fmt
   import mem_access_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      off_i,
   input  logic [1:0]      type_i,
   input  logic            sign_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] sh;

   assign sh = rdata_i >> {off_i, 3'b000};

   always_comb begin
      data_o = sh;
      if (type_i == LS_B)
         data_o = {{(XLEN-8){sign_i & sh[7]}}, sh[7:0]};
      else if (type_i == LS_H)
         data_o = {{(XLEN-16){sign_i & sh[15]}}, sh[15:0]};
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives loads/stores on a req/gnt/rvalid data bus,
// stalls upstream via mem_hold, and registers MEM/WB results.
// Ports: EX/MEM inputs (MEM_*), dbus_* request/response, mem_hold,
// misalign/bus_err pulses, registered WB_rd_addr/WB_rd_data/WB_wen.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] MEM_result,
   input  logic [XLEN-1:0] MEM_FD_rs2_data,
   input  logic [4:0]      MEM_rd_addr,
   input  logic            MEM_rmem,
   input  logic            MEM_wmem,
   input  logic            MEM_wen,
   input  logic [1:0]      MEM_mem_type,
   input  logic            MEM_mem_sign,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [3:0]      dbus_be,
   output logic [XLEN-1:0] dbus_wdata,
   input  logic            dbus_gnt,
   input  logic            dbus_rvalid,
   input  logic [XLEN-1:0] dbus_rdata,
   output logic            mem_hold,
   output logic            misalign,
   output logic            bus_err,
   output logic [4:0]      WB_rd_addr,
   output logic [XLEN-1:0] WB_rd_data,
   output logic            WB_wen
);

   localparam int CW = $clog2(RESP_TIMEOUT + 1);

   mem_state_e      state_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] wdata_d;
   logic [3:0]      be_q;
   logic            we_q;
   logic [1:0]      type_q;
   logic            sign_q;
   logic [4:0]      rd_q;
   logic            wen_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            misalign_q;
   logic            bus_err_q;
   logic            access;
   logic            mis;
   logic            start;
   logic            timeout;
   logic [XLEN-1:0] load_data;

   assign access  = MEM_rmem | MEM_wmem;
   assign mis     = misaligned(MEM_mem_type, MEM_result[1:0]);
   assign start   = access & ~mis;
   assign cnt_d   = cnt_q + 1'b1;
   assign timeout = (cnt_d == CW'(RESP_TIMEOUT));

   always_comb begin
      wdata_d = MEM_FD_rs2_data;
      if (MEM_mem_type == LS_B)
         wdata_d = {4{MEM_FD_rs2_data[7:0]}};
      else if (MEM_mem_type == LS_H)
         wdata_d = {2{MEM_FD_rs2_data[15:0]}};
   end

   mem_load_fmt #(.XLEN(XLEN)) u_fmt (
      .rdata_i (dbus_rdata),
      .off_i   (addr_q[1:0]),
      .type_i  (type_q),
      .sign_i  (sign_q),
      .data_o  (load_data)
   );

   assign dbus_req   = (state_q == MEM_REQ);
   assign dbus_we    = we_q;
   assign dbus_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign dbus_be    = be_q;
   assign dbus_wdata = wdata_q;
   assign misalign   = misalign_q;
   assign bus_err    = bus_err_q;

   // Hold is released in DONE so upstream advances exactly once per access.
   // Gated by rst so the stall drops immediately on reset.
   assign mem_hold = ~rst & (((state_q == MEM_IDLE) & start) |
                             (state_q == MEM_REQ) |
                             (state_q == MEM_RESP));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= MEM_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         type_q     <= LS_W;
         sign_q     <= 1'b0;
         rd_q       <= '0;
         wen_q      <= 1'b0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         WB_rd_addr <= '0;
         WB_rd_data <= '0;
         WB_wen     <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         unique case (state_q)
            MEM_IDLE: begin
               if (!access) begin
                  WB_rd_addr <= MEM_rd_addr;
                  WB_rd_data <= MEM_result;
                  WB_wen     <= MEM_wen;
               end else if (mis) begin
                  WB_wen     <= 1'b0;
                  misalign_q <= 1'b1;
               end else begin
                  addr_q  <= MEM_result;
                  be_q    <= store_be(MEM_mem_type, MEM_result[1:0]);
                  wdata_q <= wdata_d;
                  // Load wins when both rmem and wmem are set.
                  we_q    <= ~MEM_rmem;
                  type_q  <= MEM_mem_type;
                  sign_q  <= MEM_mem_sign;
                  rd_q    <= MEM_rd_addr;
                  wen_q   <= MEM_wen;
                  cnt_q   <= '0;
                  WB_wen  <= 1'b0;
                  state_q <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               cnt_q <= cnt_d;
               if (dbus_gnt) begin
                  WB_wen  <= 1'b0;
                  state_q <= we_q ? MEM_DONE : MEM_RESP;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  WB_wen    <= 1'b0;
                  state_q   <= MEM_DONE;
               end
            end
            MEM_RESP: begin
               cnt_q <= cnt_d;
               if (dbus_rvalid) begin
                  WB_rd_data <= load_data;
                  WB_rd_addr <= rd_q;
                  WB_wen     <= wen_q;
                  state_q    <= MEM_DONE;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  WB_wen    <= 1'b0;
                  state_q   <= MEM_DONE;
               end
            end
            MEM_DONE: begin
               WB_wen  <= 1'b0;
               state_q <= MEM_IDLE;
            end
            default: state_q <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed table, reset corner case,
// and randomized accesses checked against a behavioural model.
module tb_mem_access;
   import mem_access_pkg::*;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] MEM_result;
   logic [31:0] MEM_FD_rs2_data;
   logic [4:0]  MEM_rd_addr;
   logic        MEM_rmem;
   logic        MEM_wmem;
   logic        MEM_wen;
   logic [1:0]  MEM_mem_type;
   logic        MEM_mem_sign;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_gnt;
   logic        dbus_rvalid;
   logic [31:0] dbus_rdata;
   logic        mem_hold;
   logic        misalign;
   logic        bus_err;
   logic [4:0]  WB_rd_addr;
   logic [31:0] WB_rd_data;
   logic        WB_wen;

   mem_access #(.XLEN(32), .RESP_TIMEOUT(T)) dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_result      (MEM_result),
      .MEM_FD_rs2_data (MEM_FD_rs2_data),
      .MEM_rd_addr     (MEM_rd_addr),
      .MEM_rmem        (MEM_rmem),
      .MEM_wmem        (MEM_wmem),
      .MEM_wen         (MEM_wen),
      .MEM_mem_type    (MEM_mem_type),
      .MEM_mem_sign    (MEM_mem_sign),
      .dbus_req        (dbus_req),
      .dbus_we         (dbus_we),
      .dbus_addr       (dbus_addr),
      .dbus_be         (dbus_be),
      .dbus_wdata      (dbus_wdata),
      .dbus_gnt        (dbus_gnt),
      .dbus_rvalid     (dbus_rvalid),
      .dbus_rdata      (dbus_rdata),
      .mem_hold        (mem_hold),
      .misalign        (misalign),
      .bus_err         (bus_err),
      .WB_rd_addr      (WB_rd_addr),
      .WB_rd_data      (WB_rd_data),
      .WB_wen          (WB_wen)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Inputs, bus timing (gd: grant delay, rv: rvalid cycles after grant),
   // then expected hold/req cycle counts, lanes, WB data and pulses.
   typedef struct {
      bit        rmem;
      bit        wmem;
      bit [1:0]  typ;
      bit        sgn;
      bit [31:0] addr;
      bit [31:0] rs2;
      bit [31:0] rdata;
      bit [4:0]  rd;
      bit        wen;
      int        gd;
      int        rv;
      int        hold;
      int        req;
      bit [3:0]  be;
      bit [31:0] wdata;
      bit [31:0] data;
      int        wenp;
      bit        mis;
      bit        err;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic bubble();
      MEM_rmem        = 1'b0;
      MEM_wmem        = 1'b0;
      MEM_wen         = 1'b0;
      MEM_rd_addr     = 5'd0;
      MEM_result      = 32'hCAFE0000;
      MEM_FD_rs2_data = 32'h0;
      MEM_mem_type    = LS_W;
      MEM_mem_sign    = 1'b0;
      dbus_gnt        = 1'b0;
      dbus_rvalid     = 1'b0;
      dbus_rdata      = 32'h0BADF00D;
   endtask

   // Behavioural reference: computes expectations from the access rules.
   function automatic vec_t model(input vec_t vi);
      vec_t v;
      int off, bus;
      bit [31:0] w;
      v = vi;
      off = int'(v.addr[1:0]);
      v.hold = 0; v.req = 0; v.be = 0; v.wdata = 0;
      v.data = 0; v.wenp = 0; v.mis = 0; v.err = 0;
      if (!v.rmem && !v.wmem) begin
         v.wenp = v.wen ? 1 : 0;
         v.data = v.addr;
         return v;
      end
      if ((v.typ == LS_H && off % 2 != 0) ||
          (v.typ == LS_W && off != 0)) begin
         v.mis = 1;
         return v;
      end
      bus = v.rmem ? v.gd + 1 + v.rv : v.gd + 1;
      v.req = (v.gd + 1 > T) ? T : v.gd + 1;
      if (bus > T) begin
         v.err = 1;
         v.hold = 1 + T;
      end else begin
         v.hold = 1 + bus;
         v.wenp = (v.rmem && v.wen) ? 1 : 0;
      end
      case (v.typ)
         LS_B: begin
            v.be = 4'(32'd1 << off);
            v.wdata = {24'h0, v.rs2[7:0]} * 32'h01010101;
         end
         LS_H: begin
            v.be = 4'(32'd3 << off);
            v.wdata = {16'h0, v.rs2[15:0]} * 32'h00010001;
         end
         default: begin
            v.be = 4'hF;
            v.wdata = v.rs2;
         end
      endcase
      w = v.rdata >> (8 * off);
      if (v.typ == LS_B) begin
         w = w & 32'hFF;
         if (v.sgn && w >= 32'h80) w = w - 32'h100;
      end else if (v.typ == LS_H) begin
         w = w & 32'hFFFF;
         if (v.sgn && w >= 32'h8000) w = w - 32'h10000;
      end
      v.data = w;
      return v;
   endfunction

   // Entered at posedge+1 with the DUT idle; leaves after one bubble cycle.
   task automatic run(input vec_t v, input string nm);
      int hold_n, req_n, mis_n, err_n, wen_n, bad_req, cyc, k;
      bit in_bus, done;
      logic [31:0] wb_d;
      logic [4:0]  wb_a;
      hold_n = 0; req_n = 0; mis_n = 0; err_n = 0; wen_n = 0;
      bad_req = 0; cyc = 0; k = 0; in_bus = 0; done = 0;
      wb_d = '0; wb_a = '0;
      MEM_rmem        = v.rmem;
      MEM_wmem        = v.wmem;
      MEM_mem_type    = v.typ;
      MEM_mem_sign    = v.sgn;
      MEM_result      = v.addr;
      MEM_FD_rs2_data = v.rs2;
      MEM_rd_addr     = v.rd;
      MEM_wen         = v.wen;
      while (!done && cyc < 60) begin
         if (dbus_req && !in_bus) begin
            in_bus = 1;
            k = 0;
         end else if (in_bus) begin
            k++;
         end
         dbus_gnt    = dbus_req && (k == v.gd);
         dbus_rvalid = in_bus && (k == v.gd + v.rv);
         dbus_rdata  = dbus_rvalid ? v.rdata : 32'h0BADF00D;
         @(negedge clk);
         if (mem_hold) hold_n++;
         else done = 1;
         if (dbus_req) begin
            req_n++;
            if (dbus_addr !== {v.addr[31:2], 2'b00} ||
                dbus_be !== v.be || dbus_we !== !v.rmem ||
                (!v.rmem && dbus_wdata !== v.wdata))
               bad_req++;
         end
         if (misalign) mis_n++;
         if (bus_err) err_n++;
         if (WB_wen) begin
            wen_n++;
            wb_d = WB_rd_data;
            wb_a = WB_rd_addr;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) chk({nm, ".cycle_budget"}, 32'(cyc), 32'd0);
      bubble();
      @(negedge clk);
      if (misalign) mis_n++;
      if (bus_err) err_n++;
      if (WB_wen) begin
         wen_n++;
         wb_d = WB_rd_data;
         wb_a = WB_rd_addr;
      end
      @(posedge clk); #1;
      chk({nm, ".hold"}, 32'(hold_n), 32'(v.hold));
      chk({nm, ".req"}, 32'(req_n), 32'(v.req));
      if (v.req > 0) chk({nm, ".req_fields"}, 32'(bad_req), 32'd0);
      chk({nm, ".misalign"}, 32'(mis_n), 32'(v.mis));
      chk({nm, ".bus_err"}, 32'(err_n), 32'(v.err));
      chk({nm, ".wen_pulses"}, 32'(wen_n), 32'(v.wenp));
      if (v.wenp > 0) begin
         chk({nm, ".wb_data"}, wb_d, v.data);
         chk({nm, ".wb_rd"}, 32'(wb_a), 32'(v.rd));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      tbl[0]  = '{1,0,LS_W,0,32'h100,0,32'hDEADBEEF,5,1,0,1,
                  3,1,4'hF,0,32'hDEADBEEF,1,0,0};
      tbl[1]  = '{1,0,LS_B,1,32'h103,0,32'h80112233,6,1,0,1,
                  3,1,4'h8,0,32'hFFFFFF80,1,0,0};
      tbl[2]  = '{1,0,LS_B,0,32'h103,0,32'h80112233,7,1,0,1,
                  3,1,4'h8,0,32'h00000080,1,0,0};
      tbl[3]  = '{1,0,LS_H,1,32'h102,0,32'h80011234,8,1,0,1,
                  3,1,4'hC,0,32'hFFFF8001,1,0,0};
      tbl[4]  = '{0,1,LS_H,0,32'h206,32'h0000ABCD,0,9,0,4,1,
                  6,5,4'hC,32'hABCDABCD,0,0,0,0};
      tbl[5]  = '{1,0,LS_W,0,32'h101,0,0,10,1,0,1,
                  0,0,0,0,0,0,1,0};
      tbl[6]  = '{0,0,LS_W,0,32'h12345678,0,0,11,1,0,1,
                  0,0,0,0,32'h12345678,1,0,0};
      tbl[7]  = '{1,0,LS_W,0,32'h100,0,32'h11111111,12,1,0,100,
                  9,1,4'hF,0,0,0,0,1};
      tbl[8]  = '{0,1,LS_B,0,32'h301,32'h000000A5,0,13,0,0,1,
                  2,1,4'h2,32'hA5A5A5A5,0,0,0,0};
      tbl[9]  = '{1,0,LS_H,0,32'h100,0,32'h1234F00D,14,1,0,1,
                  3,1,4'h3,0,32'h0000F00D,1,0,0};
      tbl[10] = '{1,1,LS_W,0,32'h104,32'h99999999,32'h01020304,15,1,0,1,
                  3,1,4'hF,0,32'h01020304,1,0,0};
      tbl[11] = '{0,1,LS_W,0,32'h208,32'h11223344,0,16,0,7,1,
                  9,8,4'hF,32'h11223344,0,0,0,0};
      tbl[12] = '{1,0,LS_W,0,32'h10C,0,32'hA5A50001,17,1,0,7,
                  9,1,4'hF,0,32'hA5A50001,1,0,0};
      tbl[13] = '{0,1,LS_W,0,32'h20C,32'hCAFEBABE,0,18,0,8,1,
                  9,8,4'hF,32'hCAFEBABE,0,0,0,1};
      tbl[14] = '{0,1,LS_H,0,32'h203,32'h1234,0,19,0,0,1,
                  0,0,0,0,0,0,1,0};
      tbl[15] = '{1,0,LS_B,1,32'h101,0,32'h00007F00,20,1,1,2,
                  5,2,4'h2,0,32'h0000007F,1,0,0};

      rst = 1'b1;
      bubble();
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset.wb_wen", WB_wen, 0);
      chk("reset.wb_data", WB_rd_data, 0);
      chk("reset.wb_rd", WB_rd_addr, 0);
      chk("reset.misalign", misalign, 0);
      chk("reset.bus_err", bus_err, 0);
      chk("reset.req", dbus_req, 0);
      chk("reset.hold", mem_hold, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         run(tbl[i], $sformatf("vec%0d", i));

      // Reset while waiting for read data.
      MEM_rmem     = 1'b1;
      MEM_mem_type = LS_W;
      MEM_result   = 32'h100;
      MEM_rd_addr  = 5'd3;
      MEM_wen      = 1'b1;
      @(posedge clk); #1;
      dbus_gnt = 1'b1;
      @(posedge clk); #1;
      dbus_gnt = 1'b0;
      chk("rst_resp.hold_before", mem_hold, 1);
      chk("rst_resp.wb_before", WB_rd_data, 32'hCAFE0000);
      #2 rst = 1'b1;
      #1;
      chk("rst_resp.req", dbus_req, 0);
      chk("rst_resp.hold", mem_hold, 0);
      chk("rst_resp.wb_wen", WB_wen, 0);
      chk("rst_resp.wb_data", WB_rd_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bubble();
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h55555555;
      @(negedge clk);
      chk("rst_resp.late_req", dbus_req, 0);
      chk("rst_resp.late_hold", mem_hold, 0);
      @(posedge clk); #1;
      dbus_rvalid = 1'b0;
      dbus_rdata  = 32'h0BADF00D;
      @(negedge clk);
      chk("rst_resp.late_wen", WB_wen, 0);
      chk("rst_resp.late_data", WB_rd_data, 32'hCAFE0000);
      @(posedge clk); #1;
      run(tbl[0], "after_rst");

      for (int i = 0; i < 40; i++) begin
         rv = tbl[0];
         rv.rmem  = 1'($urandom_range(0, 1));
         rv.wmem  = 1'($urandom_range(0, 1));
         rv.typ   = 2'($urandom_range(0, 2));
         rv.sgn   = 1'($urandom_range(0, 1));
         rv.addr  = $urandom & 32'h0000_0FFF;
         rv.rs2   = $urandom;
         rv.rdata = $urandom;
         rv.rd    = 5'($urandom_range(0, 31));
         rv.wen   = 1'($urandom_range(0, 1));
         rv.gd    = ($urandom_range(0, 5) == 0) ?
                    int'($urandom_range(0, 9)) :
                    int'($urandom_range(0, 2));
         rv.rv    = ($urandom_range(0, 5) == 0) ?
                    int'($urandom_range(1, 9)) :
                    int'($urandom_range(1, 2));
         rv = model(rv);
         run(rv, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
